// File: rtl/pointer_seq_pkg.sv
// Shared opcodes, FSM state codes and sequence lengths for the IP/DP pointer-pair sequencer.
package pointer_seq_pkg;

  localparam logic [2:0] OP_FETCH = 3'd0;
  localparam logic [2:0] OP_LD_DP = 3'd1;
  localparam logic [2:0] OP_JMP   = 3'd2;
  localparam logic [2:0] OP_RD_DP = 3'd3;
  localparam logic [2:0] OP_WR_DP = 3'd4;
  localparam logic [2:0] OP_GET   = 3'd5;
  localparam logic [2:0] OP_SWAP  = 3'd6;

  localparam logic [3:0] ST_IDLE  = 4'd0;
  localparam logic [3:0] ST_FETCH = 4'd1;
  localparam logic [3:0] ST_LD_L  = 4'd2;
  localparam logic [3:0] ST_LD_H  = 4'd3;
  localparam logic [3:0] ST_SWAP  = 4'd4;
  localparam logic [3:0] ST_RD    = 4'd5;
  localparam logic [3:0] ST_WR    = 4'd6;
  localparam logic [3:0] ST_GET_L = 4'd7;
  localparam logic [3:0] ST_GET_H = 4'd8;
  localparam logic [3:0] ST_ILL   = 4'd9;

  localparam int BUSY_FETCH = 1;
  localparam int BUSY_LD_DP = 2;
  localparam int BUSY_JMP   = 3;
  localparam int BUSY_RD_DP = 1;
  localparam int BUSY_WR_DP = 1;
  localparam int BUSY_GET   = 2;
  localparam int BUSY_SWAP  = 1;
  localparam int BUSY_ILL   = 1;

  // JMP reuses the LD_DP byte-load states and is told apart later by the latched opcode.
  function automatic logic [3:0] first_state(input logic [2:0] op);
    case (op)
      OP_FETCH: first_state = ST_FETCH;
      OP_LD_DP: first_state = ST_LD_L;
      OP_JMP:   first_state = ST_LD_L;
      OP_RD_DP: first_state = ST_RD;
      OP_WR_DP: first_state = ST_WR;
      OP_GET:   first_state = ST_GET_L;
      OP_SWAP:  first_state = ST_SWAP;
      default:  first_state = ST_ILL;
    endcase
  endfunction

endpackage

// File: rtl/pointer_seq_decode.sv
// Pure state-to-strobe decoder; every strobe depends on the state register alone.
module pointer_seq_decode
  import pointer_seq_pkg::*;
(
  input  logic [3:0] state,
  output logic       addr_dp,
  output logic       n_oe_dl,
  output logic       n_oe_dh,
  output logic       cnt,
  output logic       n_we_l,
  output logic       n_we_h,
  output logic       mem_n_oe,
  output logic       mem_n_we,
  output logic       bus_drive
);

  always_comb begin
    addr_dp   = 1'b0;
    n_oe_dl   = 1'b1;
    n_oe_dh   = 1'b1;
    cnt       = 1'b0;
    n_we_l    = 1'b1;
    n_we_h    = 1'b1;
    mem_n_oe  = 1'b1;
    mem_n_we  = 1'b1;
    bus_drive = 1'b0;
    case (state)
      ST_FETCH: begin
        cnt      = 1'b1;
        mem_n_oe = 1'b0;
      end
      ST_LD_L: begin
        cnt      = 1'b1;
        mem_n_oe = 1'b0;
        n_we_l   = 1'b0;
      end
      ST_LD_H: begin
        cnt      = 1'b1;
        mem_n_oe = 1'b0;
        n_we_h   = 1'b0;
      end
      ST_RD: begin
        addr_dp  = 1'b1;
        mem_n_oe = 1'b0;
      end
      ST_WR: begin
        addr_dp   = 1'b1;
        mem_n_we  = 1'b0;
        bus_drive = 1'b1;
      end
      ST_GET_L: n_oe_dl = 1'b0;
      ST_GET_H: n_oe_dh = 1'b0;
      default: ;
    endcase
  end

endmodule

// File: rtl/pointer_sequencer.sv
// Command FSM for the IP/DP pointer pair: accepts one opcode, walks its strobe
// sequence, then pulses a response carrying fetched/read data or an error flag.
module pointer_sequencer
  import pointer_seq_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [2:0]  cmd_op,
  input  logic [7:0]  cmd_data,
  input  logic [7:0]  bus_in,
  output logic [7:0]  bus_out,
  output logic        bus_drive,
  output logic        addr_dp,
  output logic        n_oe_dl,
  output logic        n_oe_dh,
  output logic        cnt,
  output logic        n_we_l,
  output logic        n_we_h,
  output logic        selector,
  output logic        mem_n_oe,
  output logic        mem_n_we,
  output logic        rsp_valid,
  output logic [15:0] rsp_data,
  output logic        rsp_err
);

  logic [3:0]  state_q, state_d;
  logic [2:0]  op_q, op_d;
  logic [7:0]  data_q, data_d;
  logic [7:0]  lo_q, lo_d;
  logic        selector_q, selector_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [15:0] rsp_data_q, rsp_data_d;
  logic        rsp_err_q, rsp_err_d;

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    data_d      = data_q;
    lo_d        = lo_q;
    selector_d  = selector_q;
    rsp_valid_d = 1'b0;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          op_d    = cmd_op;
          data_d  = cmd_data;
          state_d = first_state(cmd_op);
        end
      end
      ST_FETCH, ST_RD: begin
        state_d     = ST_IDLE;
        rsp_valid_d = 1'b1;
        rsp_data_d  = {8'h00, bus_in};
        rsp_err_d   = 1'b0;
      end
      ST_LD_L: state_d = ST_LD_H;
      ST_LD_H: begin
        if (op_q == OP_JMP) begin
          state_d = ST_SWAP;
        end else begin
          state_d     = ST_IDLE;
          rsp_valid_d = 1'b1;
          rsp_data_d  = 16'h0000;
          rsp_err_d   = 1'b0;
        end
      end
      ST_SWAP: begin
        selector_d  = ~selector_q;
        state_d     = ST_IDLE;
        rsp_valid_d = 1'b1;
        rsp_data_d  = 16'h0000;
        rsp_err_d   = 1'b0;
      end
      ST_WR: begin
        state_d     = ST_IDLE;
        rsp_valid_d = 1'b1;
        rsp_data_d  = 16'h0000;
        rsp_err_d   = 1'b0;
      end
      // Low DP byte is parked in lo_q so rsp_data keeps the previous result until the pulse.
      ST_GET_L: begin
        lo_d    = bus_in;
        state_d = ST_GET_H;
      end
      ST_GET_H: begin
        state_d     = ST_IDLE;
        rsp_valid_d = 1'b1;
        rsp_data_d  = {bus_in, lo_q};
        rsp_err_d   = 1'b0;
      end
      ST_ILL: begin
        state_d     = ST_IDLE;
        rsp_valid_d = 1'b1;
        rsp_data_d  = 16'h0000;
        rsp_err_d   = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      op_q        <= 3'd0;
      data_q      <= 8'h00;
      lo_q        <= 8'h00;
      selector_q  <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= 16'h0000;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      data_q      <= data_d;
      lo_q        <= lo_d;
      selector_q  <= selector_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  pointer_seq_decode u_decode (
    .state     (state_q),
    .addr_dp   (addr_dp),
    .n_oe_dl   (n_oe_dl),
    .n_oe_dh   (n_oe_dh),
    .cnt       (cnt),
    .n_we_l    (n_we_l),
    .n_we_h    (n_we_h),
    .mem_n_oe  (mem_n_oe),
    .mem_n_we  (mem_n_we),
    .bus_drive (bus_drive)
  );

  assign cmd_ready = (state_q == ST_IDLE);
  assign bus_out   = bus_drive ? data_q : 8'h00;
  assign selector  = selector_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_pointer_sequencer.sv
// Bench: a pointer-pair + memory environment reacts to the strobes, while a command-level
// reference model predicts responses, pointer values and selector role.
module tb_pointer_sequencer;
  import pointer_seq_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [2:0]  cmd_op = 3'd0;
  logic [7:0]  cmd_data = 8'h00;
  logic [7:0]  bus_in;
  logic [7:0]  bus_out;
  logic        bus_drive, addr_dp, n_oe_dl, n_oe_dh, cnt, n_we_l, n_we_h;
  logic        selector, mem_n_oe, mem_n_we, rsp_valid, rsp_err;
  logic [15:0] rsp_data;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pointer_sequencer dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_data(cmd_data), .bus_in(bus_in), .bus_out(bus_out),
    .bus_drive(bus_drive), .addr_dp(addr_dp), .n_oe_dl(n_oe_dl), .n_oe_dh(n_oe_dh),
    .cnt(cnt), .n_we_l(n_we_l), .n_we_h(n_we_h), .selector(selector),
    .mem_n_oe(mem_n_oe), .mem_n_we(mem_n_we), .rsp_valid(rsp_valid),
    .rsp_data(rsp_data), .rsp_err(rsp_err)
  );

  // Environment: pointer pair A/B plus 64 KiB memory, driven only by DUT strobes.
  logic [7:0]  mem [0:65535];
  logic [15:0] pa, pb, env_ip, env_dp, env_addr, nip, ndp;
  logic        pair_clr = 1'b1;

  assign env_ip   = selector ? pb : pa;
  assign env_dp   = selector ? pa : pb;
  assign env_addr = addr_dp ? env_dp : env_ip;
  assign nip      = env_ip + {15'd0, cnt};
  assign ndp      = {n_we_h ? env_dp[15:8] : bus_in, n_we_l ? env_dp[7:0] : bus_in};

  always_comb begin
    bus_in = 8'h00;
    if (!mem_n_oe)     bus_in = mem[env_addr];
    else if (!n_oe_dl) bus_in = env_dp[7:0];
    else if (!n_oe_dh) bus_in = env_dp[15:8];
    else if (bus_drive) bus_in = bus_out;
  end

  // Reference model state (command level).
  logic [7:0]  ref_mem [0:65535];
  logic [15:0] ref_ip = 16'h0000, ref_dp = 16'h0000;
  logic        ref_sel = 1'b0;

  always @(posedge clk) begin
    if (pair_clr) begin
      for (int i = 0; i < 65536; i++) mem[i] <= ref_mem[i];
      pa <= 16'h0000;
      pb <= 16'h0000;
    end else begin
      if (selector) begin
        pb <= nip;
        pa <= ndp;
      end else begin
        pa <= nip;
        pb <= ndp;
      end
      if (!mem_n_we) mem[env_addr] <= bus_in;
    end
  end

  // Strobe word: {addr_dp, n_oe_dl, n_oe_dh, cnt, n_we_l, n_we_h, mem_n_oe, mem_n_we, bus_drive}
  logic [8:0] sw;
  assign sw = {addr_dp, n_oe_dl, n_oe_dh, cnt, n_we_l, n_we_h, mem_n_oe, mem_n_we, bus_drive};
  localparam logic [8:0] IDLE_W = 9'b0_1_1_0_1_1_1_1_0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  function automatic logic [8:0] exp_strobe(input logic [2:0] op, input int k);
    logic [8:0] w;
    w = IDLE_W;
    case (op)
      OP_FETCH: begin w[5] = 1'b1; w[2] = 1'b0; end
      OP_LD_DP, OP_JMP: begin
        if (k < 2) begin
          w[5] = 1'b1;
          w[2] = 1'b0;
          if (k == 0) w[4] = 1'b0;
          else        w[3] = 1'b0;
        end
      end
      OP_RD_DP: begin w[8] = 1'b1; w[2] = 1'b0; end
      OP_WR_DP: begin w[8] = 1'b1; w[1] = 1'b0; w[0] = 1'b1; end
      OP_GET: begin
        if (k == 0) w[7] = 1'b0;
        else        w[6] = 1'b0;
      end
      default: ;
    endcase
    return w;
  endfunction

  function automatic int exp_busy(input logic [2:0] op);
    case (op)
      OP_FETCH: return BUSY_FETCH;
      OP_LD_DP: return BUSY_LD_DP;
      OP_JMP:   return BUSY_JMP;
      OP_RD_DP: return BUSY_RD_DP;
      OP_WR_DP: return BUSY_WR_DP;
      OP_GET:   return BUSY_GET;
      OP_SWAP:  return BUSY_SWAP;
      default:  return BUSY_ILL;
    endcase
  endfunction

  task automatic ref_exec(input logic [2:0] op, input logic [7:0] d,
                          output logic [15:0] r, output logic e);
    logic [15:0] t;
    r = 16'h0000;
    e = 1'b0;
    case (op)
      OP_FETCH: begin r = {8'h00, ref_mem[ref_ip]}; ref_ip = 16'(ref_ip + 1); end
      OP_LD_DP: begin
        ref_dp = {ref_mem[16'(ref_ip + 1)], ref_mem[ref_ip]};
        ref_ip = 16'(ref_ip + 2);
      end
      OP_JMP: begin
        t       = {ref_mem[16'(ref_ip + 1)], ref_mem[ref_ip]};
        ref_dp  = 16'(ref_ip + 2);
        ref_ip  = t;
        ref_sel = ~ref_sel;
      end
      OP_RD_DP: r = {8'h00, ref_mem[ref_dp]};
      OP_WR_DP: ref_mem[ref_dp] = d;
      OP_GET:   r = ref_dp;
      OP_SWAP: begin
        t = ref_ip; ref_ip = ref_dp; ref_dp = t;
        ref_sel = ~ref_sel;
      end
      default: e = 1'b1;
    endcase
  endtask

  task automatic send(input logic [2:0] op, input logic [7:0] d);
    @(negedge clk);
    chk("ready_idle", 32'(cmd_ready), 32'd1);
    chk("rsp_pulse_width", 32'(rsp_valid), 32'd0);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = d;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  // Called right after the accepting edge; walks busy cycles and checks the response.
  task automatic finish(input logic [2:0] op, input logic [7:0] d);
    int busy;
    bit done;
    int srcs;
    logic [15:0] er;
    logic e;
    ref_exec(op, d, er, e);
    busy = 0;
    done = 1'b0;
    while (!done) begin
      @(negedge clk);
      if (rsp_valid) begin
        done = 1'b1;
      end else if (busy >= 8) begin
        chk("rsp_timeout", 32'(rsp_valid), 32'd1);
        done = 1'b1;
      end else begin
        chk("strobes", 32'(sw), 32'(exp_strobe(op, busy)));
        chk("ready_busy", 32'(cmd_ready), 32'd0);
        srcs = int'(!mem_n_oe) + int'(!n_oe_dl) + int'(!n_oe_dh) + int'(bus_drive);
        chk("one_bus_source", 32'(srcs <= 1), 32'd1);
        chk("cnt_on_ip", 32'(cnt & addr_dp), 32'd0);
        if (op == OP_WR_DP) chk("bus_out", 32'(bus_out), 32'(d));
        busy++;
      end
    end
    chk("busy_len", 32'(busy), 32'(exp_busy(op)));
    chk("ready_rsp", 32'(cmd_ready), 32'd1);
    chk("rsp_data", 32'(rsp_data), 32'(er));
    chk("rsp_err", 32'(rsp_err), 32'(e));
    chk("rsp_strobes", 32'(sw), 32'(IDLE_W));
    chk("ip", 32'(env_ip), 32'(ref_ip));
    chk("dp", 32'(env_dp), 32'(ref_dp));
    chk("selector", 32'(selector), 32'(ref_sel));
    $display("cmd op=%0d data=%02h busy=%0d rsp=%04h err=%0d ip=%04h dp=%04h sel=%0d",
             op, d, busy, rsp_data, rsp_err, env_ip, env_dp, selector);
  endtask

  task automatic do_cmd(input logic [2:0] op, input logic [7:0] d);
    send(op, d);
    finish(op, d);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 65536; i++) ref_mem[i] = 8'($urandom);
    ref_mem[16'h0000] = 8'hA5;
    ref_mem[16'h0001] = 8'h34;
    ref_mem[16'h0002] = 8'h12;
    ref_mem[16'h0003] = 8'h00;
    ref_mem[16'h0004] = 8'h80;
    ref_mem[16'h8001] = 8'h34;
    ref_mem[16'h8002] = 8'h12;
    repeat (3) @(negedge clk);
    rst      = 1'b0;
    pair_clr = 1'b0;

    // Reset state
    chk("reset_ready", 32'(cmd_ready), 32'd1);
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset_rsp_data", 32'(rsp_data), 32'd0);
    chk("reset_rsp_err", 32'(rsp_err), 32'd0);
    chk("reset_selector", 32'(selector), 32'd0);
    chk("reset_strobes", 32'(sw), 32'(IDLE_W));
    chk("reset_bus_out", 32'(bus_out), 32'd0);

    // Directed sequence
    do_cmd(OP_FETCH, 8'h00);
    do_cmd(OP_LD_DP, 8'h00);
    do_cmd(OP_GET, 8'h00);
    do_cmd(OP_JMP, 8'h00);
    do_cmd(OP_FETCH, 8'h00);
    do_cmd(OP_LD_DP, 8'h00);
    do_cmd(OP_WR_DP, 8'h5A);
    do_cmd(OP_RD_DP, 8'h00);
    do_cmd(3'd7, 8'hFF);

    // cmd_valid held high through a JMP with a different opcode queued behind it
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = OP_JMP;
    cmd_data  = 8'h00;
    @(posedge clk);
    #1 cmd_op = OP_FETCH;
    finish(OP_JMP, 8'h00);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    finish(OP_FETCH, 8'h00);

    // Reset during the second busy cycle of a JMP, with selector currently 1
    do_cmd(OP_SWAP, 8'h00);
    send(OP_JMP, 8'h00);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_ready", 32'(cmd_ready), 32'd1);
    chk("rst_mid_selector", 32'(selector), 32'd0);
    chk("rst_mid_strobes", 32'(sw), 32'(IDLE_W));
    chk("rst_mid_rsp_data", 32'(rsp_data), 32'd0);
    for (int i = 0; i < 4; i++) begin
      chk("rst_mid_no_rsp", 32'(rsp_valid), 32'd0);
      @(negedge clk);
    end
    $display("cmd reset-mid-jmp ready=%0d sel=%0d", cmd_ready, selector);
    pair_clr = 1'b1;
    @(negedge clk);
    pair_clr = 1'b0;
    ref_ip  = 16'h0000;
    ref_dp  = 16'h0000;
    ref_sel = 1'b0;

    // Randomized commands against the reference model
    for (int n = 0; n < 250; n++) begin
      logic [2:0] op;
      logic [7:0] d;
      op = 3'($urandom_range(0, 7));
      d  = 8'($urandom);
      do_cmd(op, d);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pointer_sequencer.md
# pointer_sequencer

Command-driven sequencer that generates every control strobe of the IP/DP pointer pair (address select, data-bus output enables, counting, byte write enables, role selector) plus the memory read/write strobes. It sits between the instruction decoder and the pointer pair / memory data bus. It turns single-opcode commands (fetch, load DP, jump, swap, DP memory access, read back DP) into correctly ordered multi-cycle strobe sequences, and returns fetched or read data on a response port.

## Interface
Parameters:
- none (opcodes and state encodings live in the package)

Ports:
- clk  in  1  system clock; all state changes on rising edge
- rst  in  1  synchronous, active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  sequencer can accept; high only in IDLE
- cmd_op  in  3  opcode: FETCH=0, LD_DP=1, JMP=2, RD_DP=3, WR_DP=4, GET_DP=5, SWAP=6, 7 illegal
- cmd_data  in  8  write data for WR_DP
- bus_in  in  8  shared data bus, sampled at cycle end
- bus_out  out  8  byte driven onto the data bus when bus_drive=1
- bus_drive  out  1  sequencer drives the data bus
- addr_dp  out  1  0: IP on address bus, 1: DP on address bus
- n_oe_dl / n_oe_dh  out  1 each  DP low/high byte onto data bus, active low
- cnt  out  1  increment IP at clock edge
- n_we_l / n_we_h  out  1 each  write DP low/high byte from data bus, active low
- selector  out  1  pointer role: 0 = A is IP, 1 = B is IP
- mem_n_oe / mem_n_we  out  1 each  memory read/write strobes, active low
- rsp_valid  out  1  one-cycle completion pulse per accepted command
- rsp_data  out  16  result: fetched/read byte in [7:0] with [15:8]=0; full DP for GET_DP
- rsp_err  out  1  valid with rsp_valid; 1 for illegal opcode

## Operation
- Handshake: command accepted on an edge with cmd_valid & cmd_ready. cmd_op and cmd_data are latched at acceptance.
- States: IDLE, FETCH, LD_L, LD_H, SWAP, RD, WR, GET_L, GET_H, ILL. All non-IDLE sequences return to IDLE.
- FETCH: addr_dp=0, mem_n_oe=0, cnt=1. rsp_data={8'h00,bus_in}.
- LD_DP: LD_L then LD_H. Both states: addr_dp=0, mem_n_oe=0, cnt=1. n_we_l=0 in LD_L, n_we_h=0 in LD_H. Result: DP loaded little-endian from the two bytes following IP, and IP advanced by 2.
- JMP: LD_L, LD_H, then SWAP. In SWAP, selector toggles at the end edge and all other strobes are inactive. Effect: new IP = operand, new DP = old IP+2 (return link).
- SWAP: the SWAP state alone.
- RD_DP: addr_dp=1, mem_n_oe=0. rsp_data={8'h00,bus_in}.
- WR_DP: addr_dp=1, mem_n_we=0, bus_drive=1, bus_out=latched cmd_data.
- GET_DP: n_oe_dl=0 in GET_L, capturing bus_in into rsp_data[7:0]. n_oe_dh=0 in GET_H, capturing into [15:8].
- Illegal opcode: ILL state for one cycle, no strobes asserted; response carries rsp_err=1 and rsp_data=0.
- Invariants:
  - at most one bus source at a time (mem_n_oe low, n_oe_dl low, n_oe_dh low, bus_drive);
  - mem_n_oe and mem_n_we never both low;
  - cnt only with addr_dp=0.
- All strobes are decoded from the state register only (Moore), so they are glitch-free for a full cycle.

## Timing
- Reset values: state=IDLE, cmd_ready=1, selector=0, addr_dp=0, cnt=0, bus_drive=0, bus_out=0, rsp_valid=0, rsp_data=0, rsp_err=0. All active-low strobes are 1.
- Per-command busy cycles: FETCH/RD/WR/SWAP/illegal = 1, LD_DP/GET_DP = 2, JMP = 3.
- rsp_valid pulses in the cycle after the last busy cycle (sequencer is back in IDLE). rsp_data/rsp_err hold until the next response.
- Throughput: at most one command per (busy+1) cycles; cmd_ready is low throughout a sequence.
- cmd_valid while busy is ignored; the command stays pending until cmd_ready.
- Reset mid-sequence: immediate return to IDLE, no rsp_valid, selector back to 0. Strobes that were active in the reset cycle are deasserted in the following cycle.

## Structure
- Package pointer_seq_pkg: opcode constants, state enum, busy-length constants.
- One natural sub-module: pointer_seq_decode, a purely combinational state → strobe decoder. It keeps the top-level FSM/latch logic separate and can be checked against the invariants in isolation.

## Test plan
- Reset, then FETCH with mem[0]=8'hA5 (pointer-pair model with IP=0) -> strobes low for 1 cycle, rsp_valid 2 cycles after accept, rsp_data=16'h00A5, IP=1.
- LD_DP with mem[1..2]=34,12 -> n_we_l then n_we_h, DP=16'h1234, IP=3. Then GET_DP -> rsp_data=16'h1234.
- JMP with operand bytes 00,80 at IP=3 -> selector 0→1 on the third busy edge, new IP=16'h8000, new DP=16'h0005. A following FETCH reads mem[8000].
- WR_DP cmd_data=8'h5A with DP=16'h1234, then RD_DP -> mem[1234]=5A, rsp_data=16'h005A. Bus-contention assertion never fires.
- cmd_op=7 -> 1 busy cycle, no strobes, rsp_err=1. cmd_valid held during a JMP -> not accepted until cmd_ready.
- rst asserted in the second cycle of JMP -> IDLE next cycle, no rsp_valid, selector=0, all strobes inactive.
